// File: rtl/mac_result_drain.sv
// mac_result_drain
// ----------------
// Output stage behind the bit-serial matrix MAC. It captures one M x N tile of
// 32-bit signed accumulator results, then streams the elements out in row-major
// order. Each element is arithmetic-right-shifted by the captured shift amount
// and saturated to OUT_WIDTH signed bits.
//
// Optional feature macro: MAC_RESULT_ROUNDING_EN
//   defined   : round half toward +inf (adds 2^(s-1) before the shift)
//   undefined : floor / pure truncation, no rounding adder
//
// Handshake semantics (both sides): a transfer happens on the rising clk_i edge
// where valid and ready are both high. Once valid_out is high, data_out, idx_m,
// idx_n and last_out hold until a transfer happens.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous reset, active-high
//   valid_in     MAC tile valid
//   ready_in     tile accepted on valid_in & ready_in
//   D_in         M*N*32 flat tile; element (m,n) at bits [(m*N+n)*32 +: 32]
//   shift_i      right-shift amount, sampled with the tile
//   valid_out    element valid
//   ready_out    downstream ready
//   data_out     requantized signed element
//   idx_m/idx_n  row/column of data_out
//   last_out     high with the final element of a tile
//   state_dbg_o  FSM state (0 = IDLE, 1 = DRAIN)
module mac_result_drain #(
  parameter int M         = 2,
  parameter int N         = 2,
  parameter int OUT_WIDTH = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                valid_in,
  output logic                                ready_in,
  input  logic [M*N*32-1:0]                   D_in,
  input  logic [4:0]                          shift_i,
  output logic                                valid_out,
  input  logic                                ready_out,
  output logic [OUT_WIDTH-1:0]                data_out,
  output logic [((M > 1) ? $clog2(M) : 1)-1:0] idx_m,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] idx_n,
  output logic                                last_out,
  output logic                                state_dbg_o
);

  localparam int IW_M = (M > 1) ? $clog2(M) : 1;
  localparam int IW_N = (N > 1) ? $clog2(N) : 1;
  localparam logic signed [32:0] MAX_V = (33'sd1 <<< (OUT_WIDTH - 1)) - 33'sd1;
  localparam logic signed [32:0] MIN_V = -(33'sd1 <<< (OUT_WIDTH - 1));

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e            state_q;
  logic [M*N*32-1:0] buf_q;
  logic [4:0]        shift_q;
  logic [IW_M-1:0]   idx_m_q, idx_m_d;
  logic [IW_N-1:0]   idx_n_q, idx_n_d;

  logic at_last_n, at_last_m;
  logic take_w, xfer_w;

  assign at_last_n   = (idx_n_q == IW_N'(N - 1));
  assign at_last_m   = (idx_m_q == IW_M'(M - 1));
  assign valid_out   = (state_q == DRAIN);
  assign last_out    = valid_out & at_last_n & at_last_m;
  // During DRAIN the next tile may only be taken in the final handshake cycle,
  // which keeps tiles back-to-back without ever looking at valid_in.
  assign ready_in    = (state_q == IDLE) | (last_out & ready_out);
  assign take_w      = valid_in & ready_in;
  assign xfer_w      = valid_out & ready_out;
  assign idx_m       = idx_m_q;
  assign idx_n       = idx_n_q;
  assign state_dbg_o = state_q;

  // Row-major index advance.
  always_comb begin
    idx_n_d = idx_n_q + IW_N'(1);
    idx_m_d = idx_m_q;
    if (at_last_n) begin
      idx_n_d = '0;
      idx_m_d = idx_m_q + IW_M'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      buf_q   <= '0;
      shift_q <= '0;
      idx_m_q <= '0;
      idx_n_q <= '0;
    end else if (take_w) begin
      // Covers both the IDLE capture and the capture on the last handshake.
      state_q <= DRAIN;
      buf_q   <= D_in;
      shift_q <= shift_i;
      idx_m_q <= '0;
      idx_n_q <= '0;
    end else if (xfer_w) begin
      if (last_out) begin
        state_q <= IDLE;
        idx_m_q <= '0;
        idx_n_q <= '0;
      end else begin
        idx_m_q <= idx_m_d;
        idx_n_q <= idx_n_d;
      end
    end
  end

  // Requantization of the currently selected element. 33-bit signed keeps the
  // rounding addition free of overflow.
  logic [31:0]        elem_w;
  logic signed [32:0] x_ext, sum_w, y_w;
`ifdef MAC_RESULT_ROUNDING_EN
  logic signed [32:0] rnd_w;
`endif

  always_comb begin
    elem_w = buf_q[(int'(idx_m_q) * N + int'(idx_n_q)) * 32 +: 32];
    x_ext  = signed'({elem_w[31], elem_w});
`ifdef MAC_RESULT_ROUNDING_EN
    rnd_w  = (shift_q != 5'd0) ? (33'sd1 <<< (shift_q - 5'd1)) : 33'sd0;
    sum_w  = x_ext + rnd_w;
`else
    sum_w  = x_ext;
`endif
    y_w    = sum_w >>> shift_q;
    if (y_w > MAX_V) begin
      data_out = MAX_V[OUT_WIDTH-1:0];
    end else if (y_w < MIN_V) begin
      data_out = MIN_V[OUT_WIDTH-1:0];
    end else begin
      data_out = y_w[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_mac_result_drain.sv
// Bench for mac_result_drain with M=2, N=2, OUT_WIDTH=8.
// Stimulus pushes expected {data, idx_m, idx_n, last} words into exp_q; a
// negedge monitor pops and compares on every output handshake.
module tb_mac_result_drain;

  localparam int M  = 2;
  localparam int N  = 2;
  localparam int OW = 8;
  localparam int W  = OW + 3;
`ifdef MAC_RESULT_ROUNDING_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             valid_in;
  logic             ready_in;
  logic [M*N*32-1:0] D_in;
  logic [4:0]       shift_i;
  logic             valid_out;
  logic             ready_out;
  logic [OW-1:0]    data_out;
  logic [0:0]       idx_m;
  logic [0:0]       idx_n;
  logic             last_out;
  logic             state_dbg_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [W-1:0] exp_q[$];

  mac_result_drain #(.M(M), .N(N), .OUT_WIDTH(OW)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .valid_in   (valid_in),
    .ready_in   (ready_in),
    .D_in       (D_in),
    .shift_i    (shift_i),
    .valid_out  (valid_out),
    .ready_out  (ready_out),
    .data_out   (data_out),
    .idx_m      (idx_m),
    .idx_n      (idx_n),
    .last_out   (last_out),
    .state_dbg_o(state_dbg_o)
  );

  // Clock / cycle counter
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] pack(int d, int m, int n, int l);
    return {d[OW-1:0], m[0], n[0], l[0]};
  endfunction

  function automatic logic [M*N*32-1:0] build(int a, int b, int c, int d);
    return {d, c, b, a};
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  logic [W-1:0] cur, e, held_v;
  bit held = 1'b0;

  always @(negedge clk_i) begin
    cur = {data_out, idx_m, idx_n, last_out};
    if (!rst_i) begin
      check("ready_in_rule", int'(ready_in), valid_out ? int'(last_out & ready_out) : 1);
      if (valid_out && ready_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output actual=%h required=none", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur != e) begin
            errors++;
            $display("FAIL output_word actual=%h required=%h", cur, e);
          end
        end
      end
      if (valid_out && !ready_out) begin
        if (held) check("stall_stable", int'(cur), int'(held_v));
        held   = 1'b1;
        held_v = cur;
      end else begin
        held = 1'b0;
      end
    end
  end

  // Driver tasks
  task automatic send_tile(logic [M*N*32-1:0] d, logic [4:0] s,
                           int e0, int e1, int e2, int e3, string name);
    int n;
    D_in     = d;
    shift_i  = s;
    valid_in = 1'b1;
    exp_q.push_back(pack(e0, 0, 0, 0));
    exp_q.push_back(pack(e1, 0, 1, 0));
    exp_q.push_back(pack(e2, 1, 0, 0));
    exp_q.push_back(pack(e3, 1, 1, 1));
    n = 0;
    @(negedge clk_i);
    while (!ready_in && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL %s_capture_timeout actual=%0d required=<50", name, n);
    end
    @(posedge clk_i);
    #1;
    check({name, "_first_valid"}, int'(valid_out), 1);
    check({name, "_first_idx"}, int'({idx_m, idx_n}), 0);
  endtask

  task automatic idle_inputs();
    valid_in = 1'b0;
    D_in     = {$urandom(), $urandom(), $urandom(), $urandom()};
    shift_i  = 5'($urandom_range(0, 31));
  endtask

  task automatic wait_drain(int start, int exp_cycles, string name);
    int cnt;
    cnt = start;
    while (exp_q.size() != 0 && cnt < 100) begin
      @(posedge clk_i);
      #1;
      cnt++;
    end
    check(name, cnt, exp_cycles);
  endtask

  logic [M*N*32-1:0] tile_a;
  int c0;

  initial begin
    rst_i     = 1'b1;
    valid_in  = 1'b0;
    ready_out = 1'b1;
    D_in      = '0;
    shift_i   = '0;
    tile_a    = build(100, -3, 7, 200);
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Reset state
    check("rst_valid_out", int'(valid_out), 0);
    check("rst_ready_in", int'(ready_in), 1);
    check("rst_last_out", int'(last_out), 0);
    check("rst_idx", int'({idx_m, idx_n}), 0);
    check("rst_data_out", int'($signed(data_out)), 0);
    check("rst_state", int'(state_dbg_o), 0);
    repeat (2) @(posedge clk_i);
    #1;
    check("idle_valid_out", int'(valid_out), 0);

    // Basic tile, saturation of 200
    send_tile(tile_a, 5'd0, 100, -3, 7, 127, "tile_a");
    check("tile_a_data0", int'($signed(data_out)), 100);
    check("tile_a_state", int'(state_dbg_o), 1);
    idle_inputs();
    wait_drain(0, 4, "tile_a_cycles");
    @(posedge clk_i);
    #1;
    check("tile_a_back_idle", int'(valid_out), 0);

    // Shift with/without rounding and full-range saturation
    send_tile(build(38, -38, 32'h7fff_ffff, 32'h8000_0000), 5'd2,
              ROUND ? 10 : 9, ROUND ? -9 : -10, 127, -128, "tile_s2");
    idle_inputs();
    wait_drain(0, 4, "tile_s2_cycles");

    send_tile(build(-300, 127, 128, -128), 5'd0, -128, 127, 127, -128, "tile_sat");
    idle_inputs();
    wait_drain(0, 4, "tile_sat_cycles");

    send_tile(build(-1, 32'h4000_0000, 255, -255), 5'd4,
              ROUND ? 0 : -1, 127, ROUND ? 16 : 15, -16, "tile_s4");
    idle_inputs();
    wait_drain(0, 4, "tile_s4_cycles");

    // Backpressure on element (0,1) for 3 cycles
    send_tile(tile_a, 5'd0, 100, -3, 7, 127, "tile_bp");
    idle_inputs();
    @(posedge clk_i);
    #1;
    ready_out = 1'b0;
    check("bp_idx_at_stall", int'({idx_m, idx_n}), 1);
    repeat (2) @(posedge clk_i);
    #1;
    check("bp_data_held", int'($signed(data_out)), -3);
    check("bp_idx_held", int'({idx_m, idx_n}), 1);
    @(posedge clk_i);
    #1;
    ready_out = 1'b1;
    @(posedge clk_i);
    #1;
    check("bp_resume_data", int'($signed(data_out)), 7);
    wait_drain(5, 7, "bp_total_cycles");

    // Back-to-back tiles, valid_in held high
    send_tile(tile_a, 5'd0, 100, -3, 7, 127, "b2b_first");
    c0 = cyc;
    send_tile(build(1, 2, 3, 4), 5'd0, 1, 2, 3, 4, "b2b_second");
    check("b2b_no_bubble", cyc - c0, M * N);
    check("b2b_second_data", int'($signed(data_out)), 1);
    idle_inputs();
    wait_drain(0, 4, "b2b_second_cycles");

    // Reset while element (1,0) is presented
    send_tile(tile_a, 5'd0, 100, -3, 7, 127, "tile_rst");
    idle_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_mid_idx", int'({idx_m, idx_n}), 2);
    check("rst_mid_data", int'($signed(data_out)), 7);
    ready_out = 1'b0;
    rst_i     = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    exp_q.delete();
    check("rst_mid_valid_out", int'(valid_out), 0);
    check("rst_mid_ready_in", int'(ready_in), 1);
    check("rst_mid_idx_clr", int'({idx_m, idx_n}), 0);
    check("rst_mid_last", int'(last_out), 0);
    ready_out = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i);
      #1;
      check("rst_mid_no_more", int'(valid_out), 0);
    end

    repeat (2) @(posedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
